// File: rtl/flag_serializer.sv
// flag_serializer: sends one framed word per start request on a single serial line.
// Frame layout: flag 0111110, payload MSB first, flag 0111110, then a one-cycle done pulse.
// Optional build macro BIT_STUFF_EN: after four consecutive payload ones, insert a 0
// ahead of the next payload bit, so the flag pattern never shows up inside the payload.
//
// state  | meaning
// IDLE   | line idle at 1, waiting for start with en high
// FLAG_S | start flag on the line, cnt_q = flag bit index
// DATA   | payload on the line, cnt_q = payload bits sent so far
// FLAG_E | end flag on the line, cnt_q = flag bit index
// DONE   | one cycle with done high, line idle
module flag_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [DATA_W-1:0] parIn,
  output logic              serOut,
  output logic              busy,
  output logic              done
);

  localparam int CW = ($clog2(DATA_W + 1) > 3) ? $clog2(DATA_W + 1) : 3;
  localparam logic [CW-1:0] FLAG_LAST = CW'(6);
  localparam logic [CW-1:0] FLAG_PEAK = CW'(5);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLAG_S = 3'd1,
    DATA   = 3'd2,
    FLAG_E = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              ser_q, ser_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef BIT_STUFF_EN
  logic [2:0]        ones_q, ones_d;
`endif

  // State, shift register and registered line outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BIT_STUFF_EN
      ones_q  <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BIT_STUFF_EN
      ones_q  <= ones_d;
`endif
    end
  end

  // Next state plus the line value for the cycle after the coming edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ser_d   = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef BIT_STUFF_EN
    ones_d  = ones_q;
`endif
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
`ifdef BIT_STUFF_EN
      ones_d  = 3'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = FLAG_S;
            cnt_d   = '0;
            sh_d    = parIn;
            ser_d   = 1'b0;
            busy_d  = 1'b1;
          end
        end
        FLAG_S: begin
          busy_d = 1'b1;
          if (cnt_q == FLAG_LAST) begin
            state_d = DATA;
            ser_d   = sh_q[DATA_W-1];
            sh_d    = {sh_q[DATA_W-2:0], 1'b0};
            cnt_d   = CW'(1);
`ifdef BIT_STUFF_EN
            ones_d  = {2'b00, sh_q[DATA_W-1]};
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
            ser_d = (cnt_q != FLAG_PEAK);
          end
        end
        DATA: begin
          busy_d = 1'b1;
          if (cnt_q == DATA_LAST) begin
            state_d = FLAG_E;
            cnt_d   = '0;
            ser_d   = 1'b0;
          end
`ifdef BIT_STUFF_EN
          // Stuffed zero: the pending payload bit stays at the top of sh_q.
          else if (ones_q == 3'd4) begin
            ser_d  = 1'b0;
            ones_d = 3'd0;
          end
`endif
          else begin
            ser_d = sh_q[DATA_W-1];
            sh_d  = {sh_q[DATA_W-2:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
`ifdef BIT_STUFF_EN
            ones_d = sh_q[DATA_W-1] ? ones_q + 3'd1 : 3'd0;
`endif
          end
        end
        FLAG_E: begin
          if (cnt_q == FLAG_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
            cnt_d  = cnt_q + CW'(1);
            ser_d  = (cnt_q != FLAG_PEAK);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign serOut = ser_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_flag_serializer.sv
// Testbench for flag_serializer: frame-level reference model feeding a per-cycle scoreboard.
module tb_flag_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic [7:0] parIn = 8'h00;
  logic       serOut, busy, done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [2:0] sb[$];
  bit         m_q[$];
  bit         m_busy = 1'b0;
  bit         m_last_done = 1'b0;

  flag_serializer #(.DATA_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .start  (start),
    .parIn  (parIn),
    .serOut (serOut),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Builds the full list of line bits for one frame from the framing rules.
  task automatic build_frame(input logic [7:0] d);
    int ones;
    m_q.delete();
    m_q.push_back(1'b0);
    for (int k = 0; k < 5; k++) m_q.push_back(1'b1);
    m_q.push_back(1'b0);
    ones = 0;
    for (int i = 7; i >= 0; i--) begin
`ifdef BIT_STUFF_EN
      if (ones == 4) begin
        m_q.push_back(1'b0);
        ones = 0;
      end
`endif
      m_q.push_back(d[i]);
      ones = d[i] ? ones + 1 : 0;
    end
    m_q.push_back(1'b0);
    for (int k = 0; k < 5; k++) m_q.push_back(1'b1);
    m_q.push_back(1'b0);
  endtask

  // Applies one cycle of inputs and queues the expected {serOut,busy,done} after the edge.
  task automatic drive(input bit r, input bit e, input bit s, input logic [7:0] d);
    logic [2:0] exp;
    bit b;
    @(negedge clk);
    rst = r; en = e; start = s; parIn = d;
    if (r || !e) begin
      m_q.delete();
      m_busy = 1'b0;
      exp = 3'b100;
    end else if (m_busy) begin
      if (m_q.size() > 0) begin
        b = m_q.pop_front();
        exp = {b, 2'b10};
      end else begin
        m_busy = 1'b0;
        exp = 3'b101;
      end
    end else if (s && !m_last_done) begin
      build_frame(d);
      b = m_q.pop_front();
      exp = {b, 2'b10};
      m_busy = 1'b1;
    end else begin
      exp = 3'b100;
    end
    m_last_done = exp[0];
    sb.push_back(exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 8'($urandom));
  endtask

  // Frame with start at step 0, extra start pulses and payload changes at steps 3 and 8.
  task automatic frame_with_noise(input logic [7:0] d);
    drive(1'b0, 1'b1, 1'b1, d);
    for (int k = 1; k < 26; k++)
      drive(1'b0, 1'b1, (k == 3 || k == 8), ~d);
  endtask

  // Monitor: one scoreboard entry per clock edge, sampled just after the edge.
  initial begin
    logic [2:0] e;
    logic [2:0] act;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = {serOut, busy, done};
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL line_out cycle %0d: got ser/busy/done=%b required %b", cyc, act, e);
        end
      end
    end
  end

  initial begin
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 8'hFF);
    drive(1'b1, 1'b1, 1'b1, 8'h55);
    idle(3);

    frame_with_noise(8'hA5);
    frame_with_noise(8'hFF);
    frame_with_noise(8'h3C);
    frame_with_noise(8'h00);
    frame_with_noise(8'hF7);

    // en dropped mid-frame, then a new frame two edges later
    drive(1'b0, 1'b1, 1'b1, 8'hA5);
    for (int k = 1; k < 10; k++) drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 8'h5A);
    idle(26);

    // reset mid-frame, then start together with en low
    drive(1'b0, 1'b1, 1'b1, 8'hC3);
    for (int k = 1; k < 5; k++) drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 8'h00);
    idle(3);
    drive(1'b0, 1'b0, 1'b1, 8'hFF);
    idle(3);

    // start held high through DONE to check the DONE cycle drops it
    for (int k = 0; k < 30; k++) drive(1'b0, 1'b1, 1'b1, 8'h81);
    idle(5);

    for (int k = 0; k < 600; k++)
      drive(($urandom_range(0, 149) == 0), ($urandom_range(0, 59) != 0),
            ($urandom_range(0, 7) == 0), 8'($urandom));
    idle(30);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_serializer.md
FLAG_SERIALIZER -- requirements
Module: flag_serializer

Interface
REQ-001 Parameter: DATA_W, default 8, payload width in bits.
REQ-002 clk  input  1  rising-edge clock; the block has one clock only.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en  input  1  transmit enable; low forces abort to IDLE.
REQ-005 start  input  1  one-cycle request to send one frame.
REQ-006 parIn  input  DATA_W  payload word, sampled on accepted start.
REQ-007 serOut  output  1  registered serial line, idle level 1.
REQ-008 busy  output  1  high while a frame is on the line.
REQ-009 done  output  1  one-cycle pulse after the final frame bit.

Function
REQ-010 Frame shall be: start flag 0,1,1,1,1,1,0; then payload MSB first; then end flag 0,1,1,1,1,1,0; one bit per clk.
REQ-011 FSM states shall be IDLE, FLAG_S, DATA, FLAG_E, DONE, with 3-bit registered state.
REQ-012 IDLE: serOut=1, busy=0; start=1 with en=1 at edge t shall load parIn into a shift register and enter FLAG_S.
REQ-013 First flag bit (0) shall appear on serOut in cycle t+1; busy=1 from t+1 to the last frame bit inclusive.
REQ-014 FLAG_S shall go to DATA after 7 bits. DATA shall go to FLAG_E after DATA_W payload bits plus any stuffed bits. FLAG_E shall go to DONE after 7 bits.
REQ-015 DONE shall last one cycle with done=1, busy=0, serOut=1, then return to IDLE.
REQ-016 Unstuffed frame length shall be 14+DATA_W cycles; with DATA_W=8, done is high in cycle t+23.
REQ-017 start while busy or in DONE shall be ignored; parIn changes after acceptance shall not affect the frame.
REQ-018 en=0 in any state shall, at the next edge, force IDLE, serOut=1, busy=0, and no done pulse.
REQ-019 start and en=0 in the same cycle: en wins, and the frame is not accepted.
REQ-020 A consecutive-ones counter (3 bits) shall count only payload bits; it shall clear on entering DATA and on every transmitted 0.

Reset
REQ-021 rst=1 at a clk edge shall set state=IDLE, serOut=1, busy=0, done=0, and clear the shift register and counters; rst has priority over en and start.
REQ-022 rst mid-frame shall truncate the frame immediately; no done pulse shall follow.

Configuration
REQ-023 Macro BIT_STUFF_EN defined: after four consecutive payload 1s, if a payload bit remains, insert one 0 and hold the pending payload bit.
REQ-024 With BIT_STUFF_EN, the payload region shall never contain five consecutive 1s, so 0111110 appears only as the start and end flags.
REQ-025 No stuffing after the last payload bit; the end flag's leading 0 serves that role.
REQ-026 Macro BIT_STUFF_EN undefined: no insertion logic, and the frame is always exactly 14+DATA_W bits.

Verification
REQ-027 parIn=8'hA5, start at t -> serOut t+1..t+22 = 0111110_10100101_0111110; done at t+23 only; busy t+1..t+22.
REQ-028 parIn=8'hFF, BIT_STUFF_EN -> payload = 1111_0_1111 (9 bits), done at t+24. Without the macro -> 11111111, done at t+23.
REQ-029 parIn=8'h3C, BIT_STUFF_EN -> payload = 0011110_00 (stuffed 0 after the fourth 1), 23-bit frame.
REQ-030 en dropped at t+10 -> serOut=1, busy=0 from t+11, no done pulse; start at t+12 -> new frame with first flag bit at t+13.
REQ-031 rst at t+5 -> IDLE and serOut=1 at t+6; start pulses at t+3 and t+8 during a frame -> ignored, frame unchanged.
